// File: rtl/star_spawn_scheduler.sv
// Multi-channel spawn/event pulse generator: fixed or LFSR-drawn intervals per channel,
// global pause, and a saturating tally of every pulse issued.
module star_spawn_scheduler #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_BITS  = 8,
    parameter int unsigned MIN_VAL   = 1,
    parameter int unsigned MAX_VAL   = 30,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int unsigned CFG_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                pause,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic [NUM_CH-1:0]   ch_random,
    input  logic                cfg_we,
    input  logic [CFG_W-1:0]    cfg_ch,
    input  logic [CNT_BITS-1:0] cfg_period,
    input  logic                cnt_clr,
    output logic [NUM_CH-1:0]   pulse,
    output logic [15:0]         pulse_total
);

    localparam logic [15:0]         LFSR_MASK = 16'hB400;
    localparam logic [15:0]         SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam int unsigned         RANGE     = MAX_VAL - MIN_VAL + 1;
    localparam logic [CNT_BITS-1:0] MIN_C     = CNT_BITS'(MIN_VAL);
    localparam logic [CNT_BITS-1:0] MAX_C     = CNT_BITS'(MAX_VAL);
    localparam logic [CNT_BITS-1:0] ONE_C     = CNT_BITS'(1);

    logic [15:0]         lfsr;
    logic [15:0]         lfsr_next;
    logic [CNT_BITS-1:0] per         [NUM_CH];
    logic [CNT_BITS-1:0] cnt         [NUM_CH];
    logic [CNT_BITS-1:0] draw        [NUM_CH];
    logic [CNT_BITS-1:0] next_period [NUM_CH];
    logic [NUM_CH-1:0]   cfg_sel;
    logic [CNT_BITS-1:0] cfg_clamped;
    logic [16:0]         pop;
    logic [16:0]         total_sum;

    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);
    end

    // Each channel sees the shared LFSR rotated by 2*i so channels do not lock-step.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            draw[i]        = CNT_BITS'(MIN_VAL + (32'(CNT_BITS'({lfsr, lfsr} >> (2 * i))) % RANGE));
            next_period[i] = ch_random[i] ? draw[i] : per[i];
        end
    end

    // Out-of-range channel indices match no channel, so such writes are dropped.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cfg_sel[i] = cfg_we && (cfg_ch == CFG_W'(i));
        end
    end

    always_comb begin
        if (cfg_period < MIN_C) begin
            cfg_clamped = MIN_C;
        end else if (cfg_period > MAX_C) begin
            cfg_clamped = MAX_C;
        end else begin
            cfg_clamped = cfg_period;
        end
    end

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pop = pop + 17'(pulse[i]);
        end
        total_sum = {1'b0, pulse_total} + pop;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            lfsr        <= SEED_EFF;
            pulse       <= '0;
            pulse_total <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                per[i] <= MAX_C;
                cnt[i] <= MAX_C;
            end
        end else begin
            lfsr <= lfsr_next;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (cfg_sel[i]) begin
                    per[i] <= cfg_clamped;
                end
                if (!ch_en[i]) begin
                    cnt[i]   <= next_period[i];
                    pulse[i] <= 1'b0;
                end else if (pause) begin
                    pulse[i] <= 1'b0;
                end else if (cnt[i] == ONE_C) begin
                    pulse[i] <= 1'b1;
                    cnt[i]   <= next_period[i];
                end else begin
                    cnt[i]   <= cnt[i] - ONE_C;
                    pulse[i] <= 1'b0;
                end
            end
            if (cnt_clr) begin
                pulse_total <= '0;
            end else if (total_sum[16]) begin
                pulse_total <= '1;
            end else begin
                pulse_total <= total_sum[15:0];
            end
        end
    end

endmodule

// File: doc/star_spawn_scheduler.md
# star_spawn_scheduler

Multi-channel periodic and random-interval pulse generator for the game's spawn and event logic. Each channel emits a one-cycle pulse after a fixed or pseudo-random interval, drawn from a shared LFSR and bounded to [MIN_VAL, MAX_VAL]. A global pause freezes all channels, and a saturating counter tallies every pulse issued. It sits between the game-state controller and the object/star placement logic.

## Interface
- NUM_CH, 4, number of independent channels (1..8)
- CNT_BITS, 8, interval counter width (≤16)
- MIN_VAL, 1, minimum interval in cycles (≥1)
- MAX_VAL, 30, maximum interval in cycles (MIN_VAL ≤ MAX_VAL < 2^CNT_BITS)
- LFSR_SEED, 16'hACE1, LFSR reset value (0 is replaced by 16'h0001)
- clk  in  1  system clock; all logic on rising edge
- resetN  in  1  reset, synchronous and active-low
- pause  in  1  1 = freeze all channel counters and suppress pulses
- ch_en  in  NUM_CH  per-channel enable
- ch_random  in  NUM_CH  per channel: 1 = random interval, 0 = fixed interval
- cfg_we  in  1  write strobe for a fixed-interval register
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel index for cfg_we
- cfg_period  in  CNT_BITS  fixed interval value
- cnt_clr  in  1  clear pulse_total
- pulse  out  NUM_CH  one-cycle event pulse per channel, registered
- pulse_total  out  16  saturating count of all pulses issued

## Operation
- Reset (resetN=0 at clk edge) sets: pulse=0, pulse_total=0, every per_i=MAX_VAL, every cnt_i=MAX_VAL, lfsr=LFSR_SEED (or 1 if the seed is 0).
- LFSR: 16-bit Galois, mask 16'hB400, shift right. It advances every cycle out of reset, including while paused or while channels are disabled.
- Random draw for channel i:
  - r_i is the low CNT_BITS bits of the 16-bit LFSR rotated right by 2*i.
  - draw_i = MIN_VAL + (r_i mod (MAX_VAL-MIN_VAL+1)).
  - The draw must always lie in [MIN_VAL, MAX_VAL].
- next_period_i = ch_random[i] ? draw_i : per_i.
- Per channel i, each cycle with resetN=1, evaluated in priority order:
  - ch_en[i]=0: cnt_i <= next_period_i; pulse[i] <= 0.
  - pause=1: cnt_i holds; pulse[i] <= 0.
  - cnt_i==1: pulse[i] <= 1; cnt_i <= next_period_i.
  - otherwise: cnt_i <= cnt_i-1; pulse[i] <= 0.
- Config write (cfg_we=1):
  - per_[cfg_ch] <= cfg_period, clamped to [MIN_VAL, MAX_VAL]. A value of 0 becomes MIN_VAL.
  - Writes are accepted during pause and while the channel is disabled.
  - A cfg_ch ≥ NUM_CH is ignored.
  - The new value takes effect only at that channel's next reload. An in-flight count is not altered.
  - A write coinciding with a reload: the reload uses the old per_i.
- pulse_total:
  - Each cycle it adds popcount(pulse) (the registered outputs), saturating at 16'hFFFF.
  - cnt_clr=1 loads 0 and takes priority over the increment in the same cycle.

## Timing
- A channel enabled at cycle t (first cycle with ch_en[i]=1 and pause=0) with interval P pulses at cycles t+P, then every P cycles in fixed mode.
- Pulse width is exactly 1 cycle. P=1 gives a pulse on every cycle.
- Each pause cycle extends the current interval by exactly 1 cycle. The remaining count is preserved across pause.
- Disabling mid-interval discards the remaining count. Re-enabling restarts the full interval.
- Random mode: each interval is independently drawn at the reload cycle, using the LFSR value in that cycle.
- pulse_total lags pulse by 1 cycle.
- Reset asserted mid-operation clears all state at the next clk edge, regardless of pause, cfg_we or cnt_clr.

## Test plan
- Fixed mode, write ch0 cfg_period=5, enable ch0 at cycle 10 → pulse[0] high at cycles 15, 20, 25, each 1 cycle wide; pulse_total=3 at cycle 26.
- Pause for 3 cycles starting at cycle 17 (ch0 period 5, enabled at 10) → next pulse moves from 20 to 23, then 28; no pulses during pause.
- Config clamps with MIN=1, MAX=30: cfg_period=0 → interval 1 (pulse every cycle); cfg_period=200 → interval 30. A write issued mid-interval does not change the in-flight interval.
- Random mode on all 4 channels for 10,000 cycles → every measured interval is in [1, 30]. Channels are not lock-stepped. Seed 0 still produces varying intervals.
- Simultaneous pulses: 4 channels, fixed period 3, enabled together → pulse_total increments by 4 per pulse cycle. Preload near saturation → holds at 16'hFFFF. cnt_clr in the same cycle as pulses → 0.
- Reset asserted mid-interval with pause=1 and cfg_we=1 → next cycle all pulse=0, pulse_total=0, per_i=30, and the LFSR is back to the seed. Repeating an identical stimulus reproduces an identical random pulse sequence.
